bcd2binary: RTL and testbench
=============================

# bcd2binary

Sequential BCD-to-binary converter: takes a 9-digit packed BCD value and returns its 30-bit binary equivalent using reverse double-dabble, one bit per clock. It is the inverse of the team's binary-to-BCD converter. It sits between keypad/display-side decimal registers and the binary datapath, for example parameter entry for counters and frequency words.

## Interface
- DIGITS, default 9: number of BCD digits in the input.
- BIN_W, default 30: output width. Must satisfy 2^BIN_W > 10^DIGITS - 1. It is also the iteration count.
- sys_clk  in  1  clock, rising edge.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  conversion request. Sampled only in IDLE.
- bcd_data  in  4*DIGITS  packed BCD input. Digit 0 is in bits [3:0]. Sampled on the accepting edge only.
- busy  out  1  high while a conversion is in progress.
- done  out  1  single-cycle pulse. bin_data (and err) are valid from this cycle on.
- bin_data  out  BIN_W  conversion result. Held until the next done.
- err  out  1  invalid-digit flag. Exists only with BCD2BIN_CHECK_EN; otherwise tied 0.

## Operation
- Working register: work[4*DIGITS+BIN_W-1:0].
  - Upper 4*DIGITS bits hold the BCD field.
  - Lower BIN_W bits hold the binary accumulator.
- State machine: IDLE, SHIFT.
- IDLE with start=1:
  - work <= {bcd_data, BIN_W'b0}; cnt <= 0; state SHIFT.
- IDLE with start=0: hold all state.
- SHIFT, each cycle:
  - t = work >> 1 (logical; 0 shifted into the MSB).
  - Every BCD nibble of t that is >= 8 is reduced by 3; all other nibbles are unchanged.
  - work <= adjusted t; cnt <= cnt+1.
- SHIFT with cnt == BIN_W-1 (last iteration):
  - bin_data <= low BIN_W bits of the adjusted value.
  - done <= 1; state IDLE.
- Arithmetic rules:
  - The nibble subtract is 4-bit and cannot underflow, since it only applies to values >= 8.
  - After BIN_W iterations the BCD field is all zero for any valid input. The implementation does not check this.
- start while busy is ignored. No queueing.
- bcd_data changes after the accepting edge have no effect.
- Reset (asynchronous, possible mid-conversion):
  - state IDLE; cnt, work, bin_data, done, busy, err all 0.
  - No done is produced for the aborted conversion.

## Timing
- Accepting edge is E0. Shifts occur on E1..E_BIN_W.
- done is high in the cycle following E_BIN_W: 30 cycles after E0 at the defaults.
- busy is high from E0 through E_BIN_W, i.e. BIN_W cycles. It is low in the done cycle.
- start asserted in the done cycle is accepted. Back-to-back throughput is one conversion per BIN_W+1 cycles.
- bin_data is registered and changes only on the edge that raises done.

## Configuration
- Macro: BCD2BIN_CHECK_EN.
- Defined: on the accepting edge, any digit > 9 causes:
  - no SHIFT; state stays IDLE;
  - err <= 1, done <= 1 on the next edge (E1), bin_data <= 0.
- Defined: a valid accepted start clears err to 0.
- Not defined: err is a constant 0 and there is no check. Invalid digits are converted by the same algorithm, giving a deterministic but meaningless result with the normal latency.

## Structure
- Package bcd2bin_pkg holds:
  - the DIGITS/BIN_W defaults;
  - a state typedef (IDLE, SHIFT);
  - the counter width constant, $clog2(BIN_W).
- Sub-module bcd_nibble_adj: 4-bit combinational block, out = (in >= 8) ? in-3 : in. Instantiated DIGITS times via generate.

## Test plan
- bcd_data=36'h999999999, start pulse -> done 30 cycles later; bin_data=30'h3B9AC9FF; busy high 30 cycles.
- bcd_data=36'h123456789 -> bin_data=30'h075BCD15. Then bcd_data=36'h000000000 -> bin_data=0, done still pulses.
- Back-to-back: 36'h268435455 with start held high -> 30'h0FFFFFFF, then second conversion 36'h000000010 -> 30'h00A. done pulses 31 cycles apart; start during busy ignored.
- Reset mid-conversion at cycle 12 -> all outputs 0 immediately; no done. A new start after release converts 36'h000000042 -> 30'h2A.
- With BCD2BIN_CHECK_EN: bcd_data=36'h00000000A -> err=1, done at E1, bin_data=0. A following valid 36'h000000007 -> err=0, bin_data=7.
- Without BCD2BIN_CHECK_EN: same 36'h00000000A -> err stays 0; done after 30 cycles.

Source files
------------

// File: rtl/bcd2binary_pkg.sv
// Shared types and defaults for the BCD-to-binary converter (bcd2binary).
package bcd2bin_pkg;

    localparam int DIGITS_DEF = 9;
    localparam int BIN_W_DEF  = 30;

    function automatic int cnt_width(input int bin_w);
        return (bin_w > 1) ? $clog2(bin_w) : 1;
    endfunction

    localparam int CNT_W = cnt_width(BIN_W_DEF);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/bcd2binary_nibble_adj.sv
// One BCD nibble correction step of reverse double-dabble: values >= 8 lose 3.
module bcd_nibble_adj (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    // Only applied to values >= 8, so the 4-bit subtract never wraps.
    assign nib_out = (nib_in >= 4'd8) ? (nib_in - 4'd3) : nib_in;

endmodule

// File: rtl/bcd2binary.sv
// Sequential packed-BCD to binary converter, one bit per clock (reverse double-dabble).
// Optional invalid-digit check is built when BCD2BIN_CHECK_EN is defined.
module bcd2binary
    import bcd2bin_pkg::*;
#(
    parameter int DIGITS = DIGITS_DEF,
    parameter int BIN_W  = BIN_W_DEF
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   bcd_data,
    output logic                  busy,
    output logic                  done,
    output logic [BIN_W-1:0]      bin_data,
    output logic                  err
);

    localparam int BCD_W  = 4 * DIGITS;
    localparam int WORK_W = BCD_W + BIN_W;
    localparam int CW     = cnt_width(BIN_W);
    localparam logic [CW-1:0] CNT_LAST = CW'(BIN_W - 1);

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [WORK_W-1:0] work;
    logic [WORK_W-1:0] work_sh;
    logic [WORK_W-1:0] work_adj;
    logic              accept_ok;
    logic              err_pend;

    // Shift right, then correct every BCD nibble; the binary field passes through.
    assign work_sh                  = work >> 1;
    assign work_adj[BIN_W-1:0]      = work_sh[BIN_W-1:0];

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_nibble_adj u_adj (
            .nib_in  (work_sh[BIN_W+4*g +: 4]),
            .nib_out (work_adj[BIN_W+4*g +: 4])
        );
    end

`ifdef BCD2BIN_CHECK_EN
    logic bad_digit;
    logic err_q;

    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_data[4*i +: 4] > 4'd9) bad_digit = 1'b1;
        end
    end

    // A rejected request holds off new starts for one cycle while done/err are raised.
    assign accept_ok = start && !bad_digit && !err_pend;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_pend <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            err_pend <= (state == IDLE) && start && bad_digit && !err_pend;
            if (err_pend) begin
                err_q <= 1'b1;
            end else if ((state == IDLE) && accept_ok) begin
                err_q <= 1'b0;
            end
        end
    end

    assign err = err_q;
`else
    assign err_pend  = 1'b0;
    assign accept_ok = start;
    assign err       = 1'b0;
`endif

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            work     <= '0;
            bin_data <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (err_pend) begin
                        done     <= 1'b1;
                        bin_data <= '0;
                    end else if (accept_ok) begin
                        work  <= {bcd_data, {BIN_W{1'b0}}};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    work <= work_adj;
                    cnt  <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        bin_data <= work_adj[BIN_W-1:0];
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2binary.sv
// Directed self-checking bench for bcd2binary at default DIGITS/BIN_W.
module tb_bcd2binary;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic [35:0] bcd_data;
    logic        busy;
    logic        done;
    logic [29:0] bin_data;
    logic        err;

    int errors = 0;
    int checks = 0;

    always #5 sys_clk = ~sys_clk;

    bcd2binary dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .start     (start),
        .bcd_data  (bcd_data),
        .busy      (busy),
        .done      (done),
        .bin_data  (bin_data),
        .err       (err)
    );

    // Pulse start for one cycle, then count cycles (relative to the accepting edge) until done.
    task automatic run_conv(input logic [35:0] v, output int lat, output int bcnt,
                            output logic busy_at_done);
        @(negedge sys_clk);
        bcd_data = v;
        start    = 1'b1;
        @(negedge sys_clk);
        start    = 1'b0;
        bcd_data = ~v;
        lat = -1;
        bcnt = 0;
        busy_at_done = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (done) begin
                lat = k;
                busy_at_done = busy;
                break;
            end
            if (busy) bcnt++;
            @(negedge sys_clk);
        end
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        start     = 1'b0;
        bcd_data  = '0;
        repeat (2) @(negedge sys_clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (bin_data !== 30'h0) begin errors++; $display("FAIL reset_bin: got %h expected 0", bin_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_after_reset: got done=%b busy=%b expected 0 0", done, busy); end
    endtask

    task automatic test_max();
        int lat, bcnt;
        logic bd;
        run_conv(36'h999999999, lat, bcnt, bd);
        checks++; if (lat !== 30) begin errors++; $display("FAIL max_latency: got %0d expected 30", lat); end
        checks++; if (bin_data !== 30'h3B9AC9FF) begin errors++; $display("FAIL max_value: got %h expected 3b9ac9ff", bin_data); end
        checks++; if (bcnt !== 30) begin errors++; $display("FAIL max_busy_cycles: got %0d expected 30", bcnt); end
        checks++; if (bd !== 1'b0) begin errors++; $display("FAIL busy_in_done_cycle: got %b expected 0", bd); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL max_err: got %b expected 0", err); end
    endtask

    task automatic test_values();
        int lat, bcnt;
        logic bd;
        run_conv(36'h123456789, lat, bcnt, bd);
        checks++; if (bin_data !== 30'h075BCD15) begin errors++; $display("FAIL mixed_value: got %h expected 075bcd15", bin_data); end
        checks++; if (lat !== 30) begin errors++; $display("FAIL mixed_latency: got %0d expected 30", lat); end
        @(negedge sys_clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_single_pulse: got %b expected 0", done); end
        checks++; if (bin_data !== 30'h075BCD15) begin errors++; $display("FAIL bin_hold: got %h expected 075bcd15", bin_data); end
        run_conv(36'h000000000, lat, bcnt, bd);
        checks++; if (lat !== 30) begin errors++; $display("FAIL zero_latency: got %0d expected 30", lat); end
        checks++; if (bin_data !== 30'h0) begin errors++; $display("FAIL zero_value: got %h expected 0", bin_data); end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        logic [29:0] b1, b2;
        d1 = -1; d2 = -1; b1 = '0; b2 = '0;
        @(negedge sys_clk);
        bcd_data = 36'h268435455;
        start    = 1'b1;
        @(negedge sys_clk);
        bcd_data = 36'h000000010;
        for (int k = 0; k < 120; k++) begin
            if (done) begin
                if (d1 < 0) begin
                    d1 = k; b1 = bin_data;
                end else begin
                    d2 = k; b2 = bin_data;
                    break;
                end
            end
            if (d1 >= 0 && k == d1 + 1) start = 1'b0;
            @(negedge sys_clk);
        end
        start = 1'b0;
        checks++; if (b1 !== 30'h0FFFFFFF) begin errors++; $display("FAIL b2b_first: got %h expected 0fffffff", b1); end
        checks++; if (b2 !== 30'h00A) begin errors++; $display("FAIL b2b_second: got %h expected 00a", b2); end
        checks++; if (d1 !== 30) begin errors++; $display("FAIL b2b_first_latency: got %0d expected 30", d1); end
        checks++; if (d2 - d1 !== 31) begin errors++; $display("FAIL b2b_spacing: got %0d expected 31", d2 - d1); end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        logic bd, saw_done;
        @(negedge sys_clk);
        bcd_data = 36'h999999999;
        start    = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (12) @(negedge sys_clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before_reset: got %b expected 1", busy); end
        #2 sys_rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
        checks++; if (bin_data !== 30'h0) begin errors++; $display("FAIL mid_reset_bin: got %h expected 0", bin_data); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL mid_reset_flags: got done=%b err=%b expected 0 0", done, err); end
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge sys_clk);
            if (done) saw_done = 1'b1;
        end
        checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL aborted_no_done: got %b expected 0", saw_done); end
        run_conv(36'h000000042, lat, bcnt, bd);
        checks++; if (bin_data !== 30'h2A) begin errors++; $display("FAIL post_reset_value: got %h expected 02a", bin_data); end
        checks++; if (lat !== 30) begin errors++; $display("FAIL post_reset_latency: got %0d expected 30", lat); end
    endtask

    task automatic test_invalid_digit();
        int lat, bcnt;
        logic bd;
        run_conv(36'h00000000A, lat, bcnt, bd);
`ifdef BCD2BIN_CHECK_EN
        checks++; if (lat !== 1) begin errors++; $display("FAIL bad_digit_latency: got %0d expected 1", lat); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_digit_err: got %b expected 1", err); end
        checks++; if (bin_data !== 30'h0) begin errors++; $display("FAIL bad_digit_bin: got %h expected 0", bin_data); end
        run_conv(36'h000000007, lat, bcnt, bd);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", err); end
        checks++; if (bin_data !== 30'h7) begin errors++; $display("FAIL after_err_value: got %h expected 007", bin_data); end
        checks++; if (lat !== 30) begin errors++; $display("FAIL after_err_latency: got %0d expected 30", lat); end
`else
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL nocheck_err: got %b expected 0", err); end
        checks++; if (lat !== 30) begin errors++; $display("FAIL nocheck_latency: got %0d expected 30", lat); end
`endif
    endtask

    initial begin
        test_reset();
        test_max();
        test_values();
        test_back_to_back();
        test_reset_mid();
        test_invalid_digit();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
